grad_batch_accumulator: RTL and testbench
=========================================

# grad_batch_accumulator

Mini-batch gradient accumulator on the training path, placed between the backward-pass gradient engine and the weight update unit. It sums per-sample gradient streams (weights then bias, Q8.8 signed) over 2^log2_batch samples. It then divides by the batch size with an arithmetic shift and streams the averaged gradients out under valid/ready, one element per cycle. This is the producer side of the update unit's gradient input.

## Interface
- DATA_WIDTH, 16: gradient element width, Q8.8 two's complement
- MATRIX_SIZE, 16: weight matrix dimension; N_ELEMS = MATRIX_SIZE*MATRIX_SIZE + MATRIX_SIZE
- MAX_LOG2_BATCH, 4: largest supported log2 batch size
- ACC_WIDTH, DATA_WIDTH+MAX_LOG2_BATCH: accumulator width (overflow-free by construction)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- clear  in  1  synchronous abort, same effect as reset on control state
- log2_batch  in  3  batch size exponent, latched on first element of a batch, clamped to MAX_LOG2_BATCH
- clip_value  in  DATA_WIDTH  positive clip magnitude (used only with GRAD_ACC_CLIP_EN)
- in_valid / in_ready  in/out  1  per-sample gradient stream handshake
- in_data  in  DATA_WIDTH  gradient element; order: weights row-major, then bias
- in_last  in  1  final element of a sample
- out_valid / out_ready  out/in  1  averaged stream handshake
- out_data  out  DATA_WIDTH  averaged (optionally clipped) gradient
- out_last  out  1  element N_ELEMS-1
- out_is_bias  out  1  element index >= MATRIX_SIZE*MATRIX_SIZE
- batch_done  out  1  one-cycle pulse after final output handshake
- busy  out  1  state != ACCUM or sample_count != 0
- sample_count  out  MAX_LOG2_BATCH+1  samples accepted in current batch
- err_len  out  1  sticky; sample length != N_ELEMS seen

## Operation
- States: ACCUM (reset state), DRAIN, DONE.
- ACCUM: in_ready=1. Accepted element at idx: acc[idx] = in_data sign-extended when sample_count==0 (overwrite, so no clear pass is needed), else acc[idx] + in_data. idx increments.
- Sample ends on accepted in_last, or on accepted element at idx==N_ELEMS-1. idx returns to 0 and sample_count increments. err_len is set if in_last arrives at idx != N_ELEMS-1, or if idx==N_ELEMS-1 arrives without in_last. The sample is still counted.
- When sample_count reaches 2^log2_batch: ACCUM->DRAIN, in_ready=0.
- DRAIN: out_data = acc[idx] >>> log2_batch (floor), saturated to DATA_WIDTH, then clipped if enabled. Element advances on out_valid&&out_ready. The handshake with out_last moves to DONE.
- DONE: batch_done=1 for one cycle, sample_count=0, idx=0, then back to ACCUM.
- clear or rst_n low: state ACCUM, idx=0, sample_count=0, err_len=0, all outputs 0. Accumulator contents are not reset. Clear wins over a same-cycle handshake; that element is dropped.

## Timing
- Reset values: in_ready=1 on the cycle after reset release. out_valid, out_data, out_last, out_is_bias, batch_done, busy, sample_count and err_len are all 0.
- out_valid rises 1 cycle after DRAIN entry, from a registered output stage.
- Throughput is 1 element/cycle with out_ready held high, with no bubbles. Drain takes N_ELEMS+1 cycles.
- With out_ready low, out_data, out_last and out_is_bias stay stable and out_valid stays high.
- batch_done goes high the cycle after the out_last handshake. in_ready returns the cycle after that.

## Configuration
- GRAD_ACC_CLIP_EN defined: the averaged value is clamped to [-clip_value, +clip_value].
- Not defined: clip_value is ignored and the output is the saturated average only.

## Structure
- Package grad_acc_pkg holds the N_ELEMS function, the state enum encoding (ACCUM=0, DRAIN=1, DONE=2) and the Q8.8 min/max constants.
- One sub-module, grad_shift_sat: combinational arithmetic shift, saturate, optional clip. It is reusable by the update unit.

## Test plan
All scenarios use MATRIX_SIZE=2 (N_ELEMS=6).
- Basic average: log2_batch=1, samples of all 0x0100 then all 0x0300 -> six outputs of 0x0200; out_is_bias on elements 4-5; out_last on element 5; batch_done pulse.
- Rounding: log2_batch=1, samples 0xFFFF then 0x0000 -> 0xFFFF. Samples 0x0001 then 0x0000 -> 0x0000.
- Backpressure: out_ready low for 3 cycles mid-drain -> out_data held, no element lost, total 6 handshakes.
- Clip (macro on): clip_value=0x0200, batch of 1 with 0x0500 and 0xFB00 -> 0x0200 and 0xFE00. Macro off -> 0x0500 and 0xFB00.
- Length error: in_last at element 3 -> err_len=1 and held, sample_count increments, next sample starts at idx 0.
- Reset mid-drain: rst_n low for 1 cycle during DRAIN -> out_valid=0, in_ready=1, sample_count=0 next cycle; a fresh batch averages correctly.

Source files
------------

// File: rtl/grad_acc_pkg.sv
// Shared types and constants for the gradient batch accumulator and its datapath helpers.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package grad_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Q8.8 signed range limits
  localparam logic signed [15:0] Q88_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q88_MIN = 16'sh8000;

  // Weights (row-major square matrix) followed by one bias per row
  function automatic int n_elems(input int matrix_size);
    return matrix_size * matrix_size + matrix_size;
  endfunction

endpackage

// File: rtl/grad_shift_sat.sv
// Averages an accumulator word: arithmetic shift (floor), saturate, optional clip (GRAD_ACC_CLIP_EN).
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module grad_shift_sat
  import grad_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20,
  parameter logic signed [DATA_WIDTH-1:0] SAT_MAX = Q88_MAX,
  parameter logic signed [DATA_WIDTH-1:0] SAT_MIN = Q88_MIN
) (
  input  logic [ACC_WIDTH-1:0]  acc_in,
  input  logic [2:0]            shift,
  input  logic [DATA_WIDTH-1:0] clip_value,
  output logic [DATA_WIDTH-1:0] dat_out
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_EXT =
    {{(ACC_WIDTH-DATA_WIDTH){SAT_MAX[DATA_WIDTH-1]}}, SAT_MAX};
  localparam logic signed [ACC_WIDTH-1:0] MIN_EXT =
    {{(ACC_WIDTH-DATA_WIDTH){SAT_MIN[DATA_WIDTH-1]}}, SAT_MIN};

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [DATA_WIDTH-1:0] sat;

  // Floor-divide by 2^shift, then clamp into the output word range
  always_comb begin
    shifted = $signed(acc_in) >>> shift;
    if (shifted > MAX_EXT) begin
      sat = SAT_MAX;
    end else if (shifted < MIN_EXT) begin
      sat = SAT_MIN;
    end else begin
      sat = shifted[DATA_WIDTH-1:0];
    end
  end

`ifdef GRAD_ACC_CLIP_EN
  logic signed [DATA_WIDTH-1:0] clip_pos;
  logic signed [DATA_WIDTH-1:0] clip_neg;

  // Symmetric clip to [-clip_value, +clip_value]
  always_comb begin
    clip_pos = $signed(clip_value);
    clip_neg = -clip_pos;
    if (sat > clip_pos) begin
      dat_out = clip_pos;
    end else if (sat < clip_neg) begin
      dat_out = clip_neg;
    end else begin
      dat_out = sat;
    end
  end
`else
  // Clip magnitude is only meaningful when clipping is built in
  logic unused_clip;
  assign unused_clip = ^clip_value;
  assign dat_out     = sat;
`endif

endmodule

// File: rtl/grad_batch_accumulator.sv
// Sums 2^log2_batch gradient samples, then streams the floor average (optional clip: GRAD_ACC_CLIP_EN).
// Latency: out_valid one cycle after DRAIN entry, then one element per cycle; drain is N_ELEMS+1 cycles.
// Backpressure: in_ready low outside ACCUM; output register holds data stable while out_ready is low.
module grad_batch_accumulator
  import grad_acc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int MATRIX_SIZE    = 16,
  parameter int MAX_LOG2_BATCH = 4,
  parameter int ACC_WIDTH      = DATA_WIDTH + MAX_LOG2_BATCH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [2:0]              log2_batch,
  input  logic [DATA_WIDTH-1:0]   clip_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    out_is_bias,
  output logic                    batch_done,
  output logic                    busy,
  output logic [MAX_LOG2_BATCH:0] sample_count,
  output logic                    err_len
);

  localparam int N_ELEMS = n_elems(MATRIX_SIZE);
  localparam int W_ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W   = $clog2(N_ELEMS + 1);
  localparam int CNT_W   = MAX_LOG2_BATCH + 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              lg_q, lg_d;
  logic                    err_q, err_d;
  logic                    ovld_q, ovld_d;
  logic [DATA_WIDTH-1:0]   odat_q, odat_d;
  logic                    olast_q, olast_d;
  logic                    obias_q, obias_d;

  logic [ACC_WIDTH-1:0]    acc_q [N_ELEMS];
  logic                    acc_we;
  logic [ACC_WIDTH-1:0]    acc_wdat;
  logic [ACC_WIDTH-1:0]    acc_rd;
  logic [ACC_WIDTH-1:0]    in_ext;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   avg_dat;
  logic [2:0]              lg_clamped;
  logic [2:0]              lg_eff;
  logic                    is_last_idx;
  logic                    out_hs;
  logic                    load;

  assign lg_clamped  = (log2_batch > 3'(MAX_LOG2_BATCH)) ? 3'(MAX_LOG2_BATCH) : log2_batch;
  // The batch size is taken from the very first element of a batch
  assign lg_eff      = (cnt_q == '0 && idx_q == '0) ? lg_clamped : lg_q;
  assign is_last_idx = (idx_q == IDX_W'(N_ELEMS - 1));
  // idx runs one past the end in DRAIN once all elements are fetched
  assign rd_idx      = (idx_q < IDX_W'(N_ELEMS)) ? idx_q : '0;
  assign acc_rd      = acc_q[rd_idx];
  assign in_ext      = {{MAX_LOG2_BATCH{in_data[DATA_WIDTH-1]}}, in_data};

  grad_shift_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_shift_sat (
    .acc_in     (acc_rd),
    .shift      (lg_q),
    .clip_value (clip_value),
    .dat_out    (avg_dat)
  );

  // Next-state, accumulate and output-stage control
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lg_d     = lg_q;
    err_d    = err_q;
    ovld_d   = ovld_q;
    odat_d   = odat_q;
    olast_d  = olast_q;
    obias_d  = obias_q;
    acc_we   = 1'b0;
    acc_wdat = in_ext;
    out_hs   = 1'b0;
    load     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          // A clear in the same cycle drops the element entirely
          acc_we = rst_n && !clear;
          if (cnt_q != '0) begin
            acc_wdat = acc_rd + in_ext;
          end
          lg_d = lg_eff;
          if (in_last || is_last_idx) begin
            if (in_last != is_last_idx) begin
              err_d = 1'b1;
            end
            idx_d = '0;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == (CNT_W'(1) << lg_eff)) begin
              state_d = DRAIN;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        out_hs = ovld_q && out_ready;
        load   = (idx_q < IDX_W'(N_ELEMS)) && (!ovld_q || out_ready);
        if (load) begin
          ovld_d  = 1'b1;
          odat_d  = avg_dat;
          olast_d = is_last_idx;
          obias_d = (idx_q >= IDX_W'(W_ELEMS));
          idx_d   = idx_q + IDX_W'(1);
        end else if (out_hs) begin
          ovld_d = 1'b0;
        end
        if (out_hs && olast_q) begin
          state_d = DONE;
          ovld_d  = 1'b0;
          olast_d = 1'b0;
          obias_d = 1'b0;
        end
      end
      DONE: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Control and output registers; clear behaves like reset
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      cnt_q   <= '0;
      lg_q    <= '0;
      err_q   <= 1'b0;
      ovld_q  <= 1'b0;
      odat_q  <= '0;
      olast_q <= 1'b0;
      obias_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      err_q   <= err_d;
      ovld_q  <= ovld_d;
      odat_q  <= odat_d;
      olast_q <= olast_d;
      obias_q <= obias_d;
    end
  end

  // Accumulator storage is never reset: the first sample of a batch overwrites it
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_q[idx_q[IDX_W-1:0]] <= acc_wdat;
    end
  end

  assign in_ready     = rst_n && (state_q == ACCUM);
  assign out_valid    = ovld_q;
  assign out_data     = odat_q;
  assign out_last     = olast_q;
  assign out_is_bias  = obias_q;
  assign batch_done   = (state_q == DONE);
  assign busy         = (state_q != ACCUM) || (cnt_q != '0);
  assign sample_count = cnt_q;
  assign err_len      = err_q;

endmodule

// File: tb/tb_grad_batch_accumulator.sv
module tb_grad_batch_accumulator;

  localparam int NE = 6;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  log2_batch = 3'd0;
  logic [15:0] clip_value = 16'h0200;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_is_bias;
  logic        batch_done;
  logic        busy;
  logic [4:0]  sample_count;
  logic        err_len;

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
    logic        bias;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          m_acc[NE];
  int          m_cnt = 0;
  int          m_idx = 0;
  int          m_lg = 0;
  logic        m_err = 1'b0;
  logic [15:0] smp[NE];
  logic [15:0] held;

  grad_batch_accumulator #(
    .DATA_WIDTH     (16),
    .MATRIX_SIZE    (2),
    .MAX_LOG2_BATCH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .log2_batch   (log2_batch),
    .clip_value   (clip_value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_is_bias  (out_is_bias),
    .batch_done   (batch_done),
    .busy         (busy),
    .sample_count (sample_count),
    .err_len      (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Floor average, saturate, optional clip -- computed with integer division
  function automatic logic [15:0] avg(input int s, input int lg);
    int dv;
    int q;
    int c;
    dv = 1 << lg;
    q  = s / dv;
    if (s < 0 && q * dv != s) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    c = int'(clip_value);
`ifdef GRAD_ACC_CLIP_EN
    if (q > c) q = c;
    if (q < -c) q = -c;
`else
    c = 0;
`endif
    return 16'(q);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_err = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] d, input logic l);
    logic at_end;
    if (m_cnt == 0 && m_idx == 0) m_lg = (log2_batch > 3'd4) ? 4 : int'(log2_batch);
    if (m_cnt == 0) m_acc[m_idx] = int'($signed(d));
    else m_acc[m_idx] = m_acc[m_idx] + int'($signed(d));
    at_end = (m_idx == NE - 1);
    if (l || at_end) begin
      if (l != at_end) m_err = 1'b1;
      m_idx = 0;
      m_cnt++;
      if (m_cnt == (1 << m_lg)) begin
        for (int i = 0; i < NE; i++) begin
          exp_q.push_back('{dat: avg(m_acc[i], m_lg), last: (i == NE - 1), bias: (i >= NW)});
        end
        m_cnt = 0;
      end
    end else begin
      m_idx++;
    end
  endtask

  task automatic send_elem(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_accept(d, l);
  endtask

  task automatic send_sample(input int len, input logic last_flag);
    for (int i = 0; i < len; i++) begin
      send_elem(smp[i], last_flag && (i == len - 1));
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < NE; i++) smp[i] = v;
  endtask

  task automatic wait_done(input int exp_hs);
    int n;
    n = 0;
    while (batch_done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("batch_done_seen", batch_done, 1);
    chk("handshake_count", hs_cnt, exp_hs);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("batch_done_pulse_end", batch_done, 0);
    chk("in_ready_after_done", in_ready, 1);
    hs_cnt = 0;
  endtask

  // Output scoreboard: compare every accepted element against the queue head
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed data %0h expected no output", out_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.dat);
        chk("out_last", out_last, mon_e.last);
        chk("out_is_bias", out_is_bias, mon_e.bias);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_is_bias", out_is_bias, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_err_len", err_len, 0);

    // Basic average: 0x0100 and 0x0300 -> 0x0200
    log2_batch = 3'd1;
    fill(16'h0100);
    send_sample(NE, 1'b1);
    chk("basic_cnt_one", sample_count, 1);
    chk("basic_busy", busy, 1);
    fill(16'h0300);
    send_sample(NE, 1'b1);
    chk("drain_in_ready_low", in_ready, 0);
    chk("drain_entry_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
    chk("drain_valid_rise", out_valid, 1);
    chk("basic_first_data", out_data, 16'h0200);
    wait_done(NE);

    // Floor rounding
    fill(16'hFFFF);
    send_sample(NE, 1'b1);
    fill(16'h0000);
    send_sample(NE, 1'b1);
    wait_done(NE);
    fill(16'h0001);
    send_sample(NE, 1'b1);
    fill(16'h0000);
    send_sample(NE, 1'b1);
    wait_done(NE);

    // Backpressure mid-drain
    log2_batch = 3'd0;
    for (int i = 0; i < NE; i++) smp[i] = 16'(17 * (i + 1));
    send_sample(NE, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    held = out_data;
    chk("bp_held_value", held, 16'h0022);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_data_stable", out_data, held);
      chk("bp_valid_high", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_done(NE);

    // Clip (or pass-through when clipping is not built in)
    clip_value = 16'h0200;
    smp[0] = 16'h0500; smp[1] = 16'hFB00; smp[2] = 16'h0100;
    smp[3] = 16'hFF00; smp[4] = 16'h0200; smp[5] = 16'hFE00;
    send_sample(NE, 1'b1);
    @(posedge clk);
    #1;
`ifdef GRAD_ACC_CLIP_EN
    chk("clip_first", out_data, 16'h0200);
`else
    chk("clip_first", out_data, 16'h0500);
`endif
    wait_done(NE);

    // Short sample: err_len set and held, count still advances
    log2_batch = 3'd1;
    fill(16'h0100);
    send_sample(4, 1'b1);
    chk("lenerr_set", err_len, 1);
    chk("lenerr_cnt", sample_count, 1);
    fill(16'h0300);
    send_sample(NE, 1'b1);
    wait_done(NE);
    chk("lenerr_sticky", err_len, 1);

    // Clear wins over a same-cycle element
    fill(16'h0100);
    send_sample(2, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h7000;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("clear_err_len", err_len, 0);
    chk("clear_cnt", sample_count, 0);
    chk("clear_busy", busy, 0);

    // Final element without in_last
    log2_batch = 3'd0;
    fill(16'h0040);
    send_sample(NE, 1'b0);
    wait_done(NE);
    chk("nolast_err_len", err_len, 1);

    // Clamped batch size: 7 -> 16 samples of full-scale positive
    log2_batch = 3'd7;
    fill(16'h7FFF);
    for (int s = 0; s < 16; s++) send_sample(NE, 1'b1);
    wait_done(NE);

    // Reset mid-drain, then a fresh batch
    log2_batch = 3'd0;
    fill(16'h0123);
    send_sample(NE, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cnt", sample_count, 0);
    chk("mid_rst_err_len", err_len, 0);
    exp_q.delete();
    hs_cnt = 0;
    model_reset();
    log2_batch = 3'd2;
    fill(16'h0010);
    send_sample(NE, 1'b1);
    fill(16'h0020);
    send_sample(NE, 1'b1);
    fill(16'h0030);
    send_sample(NE, 1'b1);
    fill(16'h0040);
    send_sample(NE, 1'b1);
    @(posedge clk);
    #1;
    chk("fresh_first", out_data, 16'h0028);
    wait_done(NE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
